// File: rtl/sigma_x_pulse_gen.sv
// sigma_x_pulse_gen
// Sigma-X drive pulse burst generator for braid control.
// A request (width, count) is accepted over a valid/ready handshake. The
// block then emits `count` pulses of `width` ticks each, with GAP_TICKS low
// ticks between consecutive pulses, and signals the end with a one-cycle
// done strobe. A safety SCRAM forces HALT from any state; only fault_clear
// (with SCRAM released) leaves it.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE with no SCRAM
// pending. Requests offered while not ready are ignored and never queued.
//
// Optional feature (macro PULSE_GUARD_EN): a request with a non-zero width
// below MIN_WIDTH is refused with a one-cycle reject strobe. Without the
// macro, reject is constant 0 and every width is played out.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    burst request valid
//   req_ready    block can accept a request
//   req_width    pulse width in ticks (8 bit)
//   req_count    pulses per burst (4 bit)
//   safety_scram SCRAM from safety interlock, level-sensitive
//   fault_clear  single-cycle request to leave HALT
//   pulse_out    registered drive pulse
//   busy         burst in progress (PULSE or GAP)
//   done         one-cycle burst-complete strobe
//   fault        high while in HALT
//   reject       one-cycle strobe: request refused by width guard
//   dbg_state    current FSM state (0 IDLE, 1 PULSE, 2 GAP, 3 HALT)
module sigma_x_pulse_gen #(
    parameter int MIN_WIDTH = 10,
    parameter int GAP_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_width,
    input  logic [3:0] req_count,
    input  logic       safety_scram,
    input  logic       fault_clear,
    output logic       pulse_out,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       reject,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] GAP_W = 8'(GAP_TICKS);

`ifdef PULSE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    // Guard disabled: short_req is constant 0, so reject never rises.
    localparam bit GUARD_EN = 1'b0;
`endif

    state_t     state, next_state;
    logic [7:0] width_q;      // latched pulse width, reloaded for every pulse
    logic [7:0] width_cnt;    // ticks left in the current pulse (1 = last)
    logic [7:0] gap_cnt;      // ticks left in the current gap (1 = last)
    logic [3:0] pulses_left;  // pulses left including the current one
    logic       run_q;        // low during reset, high from the first edge after
    logic       pulse_q;
    logic       done_q;
    logic       reject_q;

    logic accept;
    logic zero_req;
    logic short_req;
    logic last_tick;
    logic last_pulse;
    logic gap_end;

    assign accept     = req_valid && req_ready;
    assign zero_req   = (req_width == 8'd0) || (req_count == 4'd0);
    assign short_req  = GUARD_EN && !zero_req && (32'(req_width) < MIN_WIDTH);
    assign last_tick  = (width_cnt == 8'd1);
    assign last_pulse = (pulses_left == 4'd1);
    assign gap_end    = (gap_cnt == 8'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; SCRAM overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && !zero_req && !short_req) begin
                    next_state = S_PULSE;
                end
            end
            S_PULSE: begin
                if (last_tick) begin
                    next_state = last_pulse ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    next_state = S_PULSE;
                end
            end
            S_HALT: begin
                if (fault_clear) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (safety_scram) begin
            next_state = S_HALT;
        end
    end

    // Counters and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q     <= 8'd0;
            width_cnt   <= 8'd0;
            gap_cnt     <= 8'd0;
            pulses_left <= 4'd0;
            run_q       <= 1'b0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            // pulse_out is the registered image of the PULSE state.
            pulse_q  <= (next_state == S_PULSE);
            done_q   <= !safety_scram &&
                        ((state == S_IDLE && accept && zero_req) ||
                         (state == S_PULSE && last_tick && last_pulse));
            reject_q <= accept && short_req;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        width_q     <= req_width;
                        width_cnt   <= req_width;
                        pulses_left <= req_count;
                    end
                end
                S_PULSE: begin
                    if (last_tick) begin
                        width_cnt   <= width_q;
                        pulses_left <= pulses_left - 4'd1;
                        gap_cnt     <= GAP_W;
                    end else begin
                        width_cnt <= width_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                S_HALT: begin
                    width_cnt   <= 8'd0;
                    gap_cnt     <= 8'd0;
                    pulses_left <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ready = run_q && (state == S_IDLE) && !safety_scram;
        busy      = (state == S_PULSE) || (state == S_GAP);
        fault     = (state == S_HALT);
        pulse_out = pulse_q;
        done      = done_q;
        reject    = reject_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_sigma_x_pulse_gen.sv
// tb_sigma_x_pulse_gen
// Self-checking bench for sigma_x_pulse_gen. The driver issues bursts and
// pushes a burst descriptor {kind, width, count} into exp_q when a request
// is offered to a ready DUT. The monitor, on every falling edge, pops a
// descriptor after each observed handshake and derives the expected
// waveform arithmetically from width, count and GAP_TICKS.
module tb_sigma_x_pulse_gen;
    localparam int MIN_WIDTH = 10;
    localparam int GAP_TICKS = 4;
    localparam int W         = 14;

`ifdef PULSE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_width;
    logic [3:0] req_count;
    logic       safety_scram;
    logic       fault_clear;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic       fault;
    logic       reject;
    logic [1:0] dbg_state;

    sigma_x_pulse_gen #(
        .MIN_WIDTH(MIN_WIDTH),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_width   (req_width),
        .req_count   (req_count),
        .safety_scram(safety_scram),
        .fault_clear (fault_clear),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .reject      (reject),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: kind 1 = refused by width guard, kind 0 = completes with done.
    function automatic logic [W-1:0] model_desc(input logic [7:0] w, input logic [3:0] c);
        logic kind;
        kind = GUARD && (w != 8'd0) && (c != 4'd0) && (int'(w) < MIN_WIDTH);
        return {1'b0, kind, w, c};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic         m_active = 1'b0;
    logic         m_pend   = 1'b0;
    logic         m_halted = 1'b0;
    int           m_k      = 0;
    int           m_total  = 0;
    logic [W-1:0] m_desc   = '0;

    always @(negedge clk) begin
        logic e_pulse, e_busy, e_done, e_rej, e_fault, e_ready;
        int   w, c, period;
        logic kind;
        if (!rst_n) begin
            chk("outputs_in_reset", 32'({req_ready, pulse_out, busy, done, fault, reject}), 32'd0);
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_halted = 1'b0;
            exp_q.delete();
        end else begin
            if (m_pend) begin
                chk("accept_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    m_desc   = exp_q.pop_front();
                    m_active = 1'b1;
                    m_k      = 0;
                end
                m_pend = 1'b0;
            end
            e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_rej   = 1'b0; e_fault = 1'b0; e_ready = !safety_scram;
            if (m_halted) begin
                e_fault = 1'b1;
                e_ready = 1'b0;
            end else if (m_active) begin
                kind   = m_desc[12];
                w      = int'(m_desc[11:4]);
                c      = int'(m_desc[3:0]);
                period = w + GAP_TICKS;
                m_total = (kind || w == 0 || c == 0) ? 0 : c * w + (c - 1) * GAP_TICKS;
                m_k++;
                e_busy  = (m_k <= m_total);
                e_pulse = e_busy && (((m_k - 1) % period) < w);
                e_done  = !kind && (m_k == m_total + 1);
                e_rej   = kind && (m_k == 1);
                e_ready = (m_k == m_total + 1) ? !safety_scram : 1'b0;
            end
            chk("pulse_out", 32'(pulse_out), 32'(e_pulse));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("done",      32'(done),      32'(e_done));
            chk("reject",    32'(reject),    32'(e_rej));
            chk("fault",     32'(fault),     32'(e_fault));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            if (m_active && m_k == m_total + 1) m_active = 1'b0;
            if (safety_scram) begin
                m_halted = 1'b1;
                m_active = 1'b0;
            end else if (m_halted) begin
                if (fault_clear) m_halted = 1'b0;
            end else if (req_valid && req_ready) begin
                m_pend = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] w, input logic [3:0] c);
        int  waited;
        bit  ok;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_width = w;
        req_count = c;
        waited = 0;
        ok = 0;
        while (!ok && waited < 6000) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(model_desc(w, c));
                ok = 1;
            end else begin
                waited++;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_width = 8'($urandom_range(0, 255));
        req_count = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((m_active || m_pend || m_halted || exp_q.size() != 0) && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 6000) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_width    = 8'd0;
        req_count    = 4'd0;
        safety_scram = 1'b0;
        fault_clear  = 1'b0;
        #1;
        chk("reset_state", 32'({req_ready, pulse_out, busy, done, fault, reject}), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        send(8'd12, 4'd1);  wait_idle();
        send(8'd10, 4'd3);  wait_idle();

        // SCRAM in the middle of the second pulse, then recovery.
        send(8'd20, 4'd2);
        cycles(30);
        safety_scram = 1'b1;
        cycles(1);
        safety_scram = 1'b0;
        cycles(3);
        safety_scram = 1'b1;  // SCRAM wins over fault_clear
        fault_clear  = 1'b1;
        cycles(1);
        safety_scram = 1'b0;
        fault_clear  = 1'b0;
        cycles(2);
        fault_clear = 1'b1;
        cycles(1);
        fault_clear = 1'b0;
        cycles(2);

        // SCRAM and request in the same IDLE cycle: no accept.
        safety_scram = 1'b1;
        req_valid    = 1'b1;
        req_width    = 8'd8;
        req_count    = 4'd1;
        cycles(1);
        req_valid    = 1'b0;
        safety_scram = 1'b0;
        cycles(1);
        fault_clear = 1'b1;
        cycles(1);
        fault_clear = 1'b0;
        cycles(2);

        send(8'd5, 4'd2);   wait_idle();
        send(8'd0, 4'd4);   wait_idle();
        send(8'd8, 4'd0);   wait_idle();
        send(8'd9, 4'd1);   wait_idle();
        send(8'd10, 4'd1);  wait_idle();

        // Asynchronous reset in the middle of a long pulse.
        send(8'd50, 4'd1);
        cycles(10);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 32'({req_ready, pulse_out, busy, done, fault, reject}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cycles(3);

        send(8'd255, 4'd15); wait_idle();

        // Requests offered while busy are ignored.
        send(8'd15, 4'd2);
        repeat (10) begin
            req_valid = 1'b1;
            req_width = 8'($urandom_range(0, 255));
            req_count = 4'($urandom_range(0, 15));
            cycles(1);
        end
        req_valid = 1'b0;
        wait_idle();

        // Random bursts, some back to back.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] w;
            logic [3:0] c;
            w = 8'($urandom_range(0, 30));
            c = 4'($urandom_range(0, 6));
            send(w, c);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigma_x_pulse_gen.md
SIGMA_X_PULSE_GEN -- requirements
Module: sigma_x_pulse_gen

Interface
REQ-001 Parameter: MIN_WIDTH, default 10, minimum legal pulse width in clk ticks (adiabatic limit at 2 GHz).
REQ-002 Parameter: GAP_TICKS, default 4, low ticks inserted between consecutive pulses of one burst; legal range 1..255.
REQ-003 Port: clk  input  1  system clock, single clock domain, rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  1  pulse-burst request valid.
REQ-006 Port: req_ready  output  1  block can accept a request.
REQ-007 Port: req_width  input  8  pulse width in ticks.
REQ-008 Port: req_count  input  4  pulses in burst.
REQ-009 Port: safety_scram  input  1  SCRAM from safety interlock, level-sensitive.
REQ-010 Port: fault_clear  input  1  single-cycle request to leave HALT.
REQ-011 Port: pulse_out  output  1  registered Sigma-X drive pulse to braid control.
REQ-012 Port: busy  output  1  high while a burst is in progress.
REQ-013 Port: done  output  1  one-cycle burst-complete strobe.
REQ-014 Port: fault  output  1  high while in HALT.
REQ-015 Port: reject  output  1  one-cycle strobe: request refused by width guard.

Function
REQ-016 FSM states SHALL be IDLE, PULSE, GAP, HALT.
REQ-017 req_ready SHALL equal (state==IDLE) AND NOT safety_scram, combinationally.
REQ-018 Handshake SHALL complete in cycle T when req_valid AND req_ready; req_width and req_count latch at that edge.
REQ-019 If latched width==0 or count==0, no pulse SHALL be emitted and done SHALL be high in T+1, state IDLE.
REQ-020 Otherwise pulse_out SHALL be high from T+1 for exactly width cycles.
REQ-021 Between pulses pulse_out SHALL be low for exactly GAP_TICKS cycles (state GAP); no gap after the last pulse.
REQ-022 done SHALL be high for one cycle in the first cycle after the last pulse high cycle; state is IDLE and req_ready may be high in that same cycle.
REQ-023 busy SHALL be high exactly when state is PULSE or GAP.
REQ-024 Total burst length SHALL be count*width + (count-1)*GAP_TICKS cycles; counters SHALL not wrap (width 255, count 15 supported).
REQ-025 safety_scram high in any cycle from any state SHALL move FSM to HALT at the next edge; pulse_out low and fault high from that edge; done not asserted.
REQ-026 safety_scram and req_valid in the same IDLE cycle: request SHALL NOT be accepted; HALT entered.
REQ-027 In HALT, fault_clear high with safety_scram low SHALL return to IDLE next edge; scram takes priority over fault_clear.
REQ-028 req_valid in non-IDLE states SHALL be ignored; no queuing.

Reset
REQ-029 During rst_n low all outputs SHALL be 0 immediately (asynchronously), including mid-pulse; state IDLE; counters 0.
REQ-030 After rst_n rises, req_ready SHALL follow REQ-017 from the first edge; no pending burst resumes.

Configuration
REQ-031 Macro PULSE_GUARD_EN defined: accepted request with 0 < width < MIN_WIDTH SHALL emit no pulse, assert reject in T+1, no done, return to IDLE.
REQ-032 Macro PULSE_GUARD_EN undefined: reject SHALL be tied 0 and every width runs per REQ-019..REQ-022.

Verification
REQ-033 width=12, count=1 accepted at T -> pulse_out high T+1..T+12, done at T+13, busy high T+1..T+12.
REQ-034 width=10, count=3, GAP_TICKS=4 -> pulses 10 high/4 low/10/4/10, done at T+39.
REQ-035 scram pulsed mid second pulse of width=20,count=2 -> pulse_out low next edge, fault=1, no done; fault_clear with scram low -> IDLE, req_ready=1.
REQ-036 width=5, count=2 -> with PULSE_GUARD_EN reject at T+1 and no pulse; without it two 5-tick pulses.
REQ-037 rst_n low during pulse of width=50 -> pulse_out 0 without clock edge; after release, IDLE and req_ready=1.
REQ-038 width=0, count=4 and width=8, count=0 -> done at T+1, pulse_out never high.
